// File: rtl/reg_bus_xfer.sv
// Register file with a sequenced, tri-stated transfer bus (copy, optional swap).
// Optional feature: define BUS_SWAP_EN to build the swap sequence and temp register.
module reg_bus_xfer #(
  parameter int WIDTH = 4,
  parameter int NREGS = 4,
  parameter int SELW  = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_en,
  input  logic [SELW-1:0]  load_sel,
  input  logic [WIDTH-1:0] load_data,
  input  logic             xfer_req,
  input  logic [SELW-1:0]  src_sel,
  input  logic [SELW-1:0]  dst_sel,
  input  logic             xfer_swap,
  output logic             xfer_busy,
  output logic             xfer_done,
  output logic             xfer_err,
  output logic [WIDTH-1:0] bus,
  input  logic [SELW-1:0]  rd_sel,
  output logic [WIDTH-1:0] rd_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_LATCH,
    S_DONE
`ifdef BUS_SWAP_EN
    , S_TMP,
    S_MOVE,
    S_WB
`endif
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [SELW-1:0]  r_src, r_dst;
  logic [WIDTH-1:0] r_regs [NREGS];
  logic             r_busy, r_done, r_err;
  logic             w_accept, w_reject, w_bus_oe;
  logic [WIDTH-1:0] w_bus_val;
`ifdef BUS_SWAP_EN
  logic [WIDTH-1:0] r_temp;
`else
  logic             w_unused_swap;
  assign w_unused_swap = xfer_swap;
`endif

  function automatic logic in_range(input logic [SELW-1:0] s);
    return 32'(s) < 32'(NREGS);
  endfunction

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_reject    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (xfer_req) begin
          if (in_range(src_sel) && in_range(dst_sel)) begin
            w_accept = 1'b1;
`ifdef BUS_SWAP_EN
            w_state_nxt = xfer_swap ? S_TMP : S_DRIVE;
`else
            w_state_nxt = S_DRIVE;
`endif
          end else begin
            w_reject = 1'b1;
          end
        end
      end
      S_DRIVE: w_state_nxt = S_LATCH;
      S_LATCH: w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
`ifdef BUS_SWAP_EN
      S_TMP:   w_state_nxt = S_MOVE;
      S_MOVE:  w_state_nxt = S_WB;
      S_WB:    w_state_nxt = S_DONE;
`endif
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Bus enable and source decode only from the state register, so the enable cannot glitch.
  always_comb begin
    w_bus_oe  = 1'b0;
    w_bus_val = r_regs[r_src];
    case (r_state)
      S_DRIVE, S_LATCH: w_bus_oe = 1'b1;
`ifdef BUS_SWAP_EN
      S_TMP:  w_bus_oe = 1'b1;
      S_MOVE: begin
        w_bus_oe  = 1'b1;
        w_bus_val = r_regs[r_dst];
      end
      S_WB: begin
        w_bus_oe  = 1'b1;
        w_bus_val = r_temp;
      end
`endif
      default: w_bus_oe = 1'b0;
    endcase
  end

  assign bus = w_bus_oe ? w_bus_val : 'z;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
      r_done  <= (w_state_nxt == S_DONE);
      r_err   <= w_reject;
    end
  end

  // Latching takes the internal bus value, which is what the bus carries in these states.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_regs <= '{default: '0};
      r_src  <= '0;
      r_dst  <= '0;
`ifdef BUS_SWAP_EN
      r_temp <= '0;
`endif
    end else begin
      if (r_state == S_IDLE && load_en && in_range(load_sel))
        r_regs[load_sel] <= load_data;
      if (w_accept) begin
        r_src <= src_sel;
        r_dst <= dst_sel;
      end
      case (r_state)
        S_LATCH: r_regs[r_dst] <= w_bus_val;
`ifdef BUS_SWAP_EN
        S_TMP:   r_temp        <= w_bus_val;
        S_MOVE:  r_regs[r_src] <= w_bus_val;
        S_WB:    r_regs[r_dst] <= w_bus_val;
`endif
        default: ;
      endcase
    end
  end

  assign xfer_busy = r_busy;
  assign xfer_done = r_done;
  assign xfer_err  = r_err;
  assign rd_data   = in_range(rd_sel) ? r_regs[rd_sel] : '0;

endmodule
